// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
//
// Switch allocator and output-credit scheduler for a 5-port mesh router
// (port index 0=N, 1=S, 2=E, 3=W, 4=L). Each output runs its own round-robin
// arbiter over the inputs whose head flit is routed to it. An output only
// arbitrates while it holds a downstream credit. The winners are registered
// into pop, crossbar-select and output-enable strobes.
//
// Parameters
//   CREDITS  downstream buffer depth per output (1..7); credit reset value
//   PORT_EN  bit p = 1 when port p exists (as both input and output)
//
// Ports
//   clk           router clock, rising edge
//   rst           asynchronous active-low reset
//   req_valid_i   [5]   input i holds a valid head flit
//   req_port_i    [15]  3-bit routed destination per input
//   credit_inc_i  [5]   per output: downstream freed one slot (pulse)
//   pop_o         [5]   registered: dequeue head flit of input i
//   port_en_o     [5]   registered: output o transmits this cycle
//   port_sel_o    [15]  registered: 3-bit source input per output (crossbar)
//   credit_cnt_o  [15]  3-bit current credit count per output
//   err_o               sticky protocol-error flag (cleared by reset only)
// -----------------------------------------------------------------------------
module switch_allocator #(
  parameter int unsigned CREDITS = 4,
  parameter logic [4:0]  PORT_EN = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req_valid_i,
  input  logic [14:0] req_port_i,
  input  logic [4:0]  credit_inc_i,
  output logic [4:0]  pop_o,
  output logic [4:0]  port_en_o,
  output logic [14:0] port_sel_o,
  output logic [14:0] credit_cnt_o,
  output logic        err_o
);

  localparam int         NP       = 5;
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);
  // Destination codes 5..7 and disabled ports read as "not a legal target".
  localparam logic [7:0] DEST_OK  = {3'b000, PORT_EN};

  logic [2:0] ptr_q    [NP];
  logic [2:0] credit_q [NP];
  logic [2:0] credit_d [NP];
  logic [2:0] dest     [NP];
  logic [4:0] req_mat  [NP];  // req_mat[o][i]: input i requests output o
  logic [2:0] winner   [NP];
  logic [4:0] grant;
  logic [4:0] pop_d;
  logic       req_err;
  logic       cred_err;

  // (base + off) mod 5 for base in 0..4, off in 0..4.
  function automatic logic [2:0] wrap5(input logic [2:0] base, input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= 5) s = s - 5;
    return s[2:0];
  endfunction

  // Request matrix and illegal-destination detection. An input whose flit
  // was popped at the last edge is masked: its head is still being consumed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    req_err = 1'b0;
    for (int i = 0; i < NP; i++) begin
      dest[i] = req_port_i[i*3 +: 3];
      if (req_valid_i[i] && PORT_EN[i] && !DEST_OK[dest[i]]) req_err = 1'b1;
    end
    for (int o = 0; o < NP; o++) begin
      req_mat[o] = '0;
      for (int i = 0; i < NP; i++) begin
        req_mat[o][i] = req_valid_i[i] && PORT_EN[i] && DEST_OK[dest[i]] &&
                        !pop_o[i] && (dest[i] == 3'(o));
      end
    end
  end

  // Per-output round-robin: first requester scanning from ptr upward, mod 5.
  // Outputs with zero credits do not arbitrate at all.
  always_comb begin : arb
    logic [2:0] cand;
    cand = '0;
    for (int o = 0; o < NP; o++) begin
      grant[o]  = 1'b0;
      winner[o] = '0;
      if (credit_q[o] != 3'd0) begin
        for (int k = 0; k < NP; k++) begin
          cand = wrap5(ptr_q[o], k);
          if (!grant[o] && req_mat[o][cand]) begin
            grant[o]  = 1'b1;
            winner[o] = cand;
          end
        end
      end
    end
  end

  // Each input names exactly one output, so at most one grant lands on it.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      pop_d[i] = 1'b0;
      for (int o = 0; o < NP; o++) begin
        if (grant[o] && (winner[o] == 3'(i))) pop_d[i] = 1'b1;
      end
    end
  end

  // Credit bookkeeping: a grant and a return in the same cycle cancel out.
  // A return into a full counter is a protocol error and is dropped.
  always_comb begin
    cred_err = 1'b0;
    for (int o = 0; o < NP; o++) begin
      credit_d[o]            = credit_q[o];
      credit_cnt_o[o*3 +: 3] = credit_q[o];
      if (grant[o] && !credit_inc_i[o]) begin
        credit_d[o] = credit_q[o] - 3'd1;
      end else if (!grant[o] && credit_inc_i[o]) begin
        if (credit_q[o] >= CRED_MAX) cred_err = 1'b1;
        else                         credit_d[o] = credit_q[o] + 3'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_o      <= '0;
      port_en_o  <= '0;
      port_sel_o <= '0;
      err_o      <= 1'b0;
      // NOTE: pointer and credit arrays are reset explicitly; they are
      // control state and the arbiter must start from a known position.
      for (int o = 0; o < NP; o++) begin
        ptr_q[o]    <= '0;
        credit_q[o] <= CRED_MAX;
      end
    end else begin
      pop_o     <= pop_d;
      port_en_o <= grant;
      err_o     <= err_o | req_err | cred_err;
      for (int o = 0; o < NP; o++) begin
        credit_q[o] <= credit_d[o];
        if (grant[o]) begin
          ptr_q[o]               <= wrap5(winner[o], 1);
          port_sel_o[o*3 +: 3]   <= winner[o];
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;

  logic        clk;
  logic        rst;
  logic [4:0]  req_valid_i;
  logic [14:0] req_port_i;
  logic [4:0]  credit_inc_i;
  logic [4:0]  pop_o;
  logic [4:0]  port_en_o;
  logic [14:0] port_sel_o;
  logic [14:0] credit_cnt_o;
  logic        err_o;

  // Second instance with port N removed, driven separately.
  logic [4:0]  pe_req_valid;
  logic [14:0] pe_req_port;
  logic [4:0]  pe_credit_inc;
  logic [4:0]  pe_pop;
  logic [4:0]  pe_port_en;
  logic [14:0] pe_port_sel;
  logic [14:0] pe_credit_cnt;
  logic        pe_err;

  int total = 0;
  int bad   = 0;

  switch_allocator dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_port_i(req_port_i), .credit_inc_i(credit_inc_i),
    .pop_o(pop_o), .port_en_o(port_en_o), .port_sel_o(port_sel_o),
    .credit_cnt_o(credit_cnt_o), .err_o(err_o)
  );

  switch_allocator #(.CREDITS(4), .PORT_EN(5'b11110)) dut_pe (
    .clk(clk), .rst(rst),
    .req_valid_i(pe_req_valid), .req_port_i(pe_req_port), .credit_inc_i(pe_credit_inc),
    .pop_o(pe_pop), .port_en_o(pe_port_en), .port_sel_o(pe_port_sel),
    .credit_cnt_o(pe_credit_cnt), .err_o(pe_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dest(input int i, input logic [2:0] d);
    req_port_i[i*3 +: 3] = d;
  endtask

  function automatic logic [2:0] sel(input int o);
    return port_sel_o[o*3 +: 3];
  endfunction

  function automatic logic [2:0] cnt(input int o);
    return credit_cnt_o[o*3 +: 3];
  endfunction

  // Pulse reset between edges and clear all stimulus.
  task automatic reset_dut();
    req_valid_i  = '0;
    req_port_i   = '0;
    credit_inc_i = '0;
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  int n;
  logic [2:0] rr_exp [5] = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1};

  initial begin
    rst = 1'b0;
    req_valid_i = '0; req_port_i = '0; credit_inc_i = '0;
    pe_req_valid = '0; pe_req_port = '0; pe_credit_inc = '0;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_cnt_held", credit_cnt_o, 15'o44444);
    check("rst_pop_held", pop_o, 5'b0);
    rst = 1'b1;
    step();
    check("rst_cnt", credit_cnt_o, 15'o44444);
    check("rst_pop", pop_o, 5'b0);
    check("rst_en", port_en_o, 5'b0);
    check("rst_sel", port_sel_o, 15'b0);
    check("rst_err", err_o, 1'b0);

    // ---------------- single request E -> L ----------------
    req_valid_i = 5'b00100;
    set_dest(2, 3'd4);
    step();
    check("single_pop", pop_o, 5'b00100);
    check("single_en", port_en_o, 5'b10000);
    check("single_sel", sel(4), 3'd2);
    check("single_cnt", cnt(4), 3'd3);
    step();
    check("single_mask_pop", pop_o, 5'b00000);
    check("single_mask_en", port_en_o, 5'b00000);
    step();
    check("single_second_pop", pop_o, 5'b00100);
    check("single_second_cnt", cnt(4), 3'd2);

    // ---------------- round robin on output L ----------------
    reset_dut();
    req_valid_i = 5'b01011;
    set_dest(0, 3'd4); set_dest(1, 3'd4); set_dest(3, 3'd4);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr_pop_%0d", k), pop_o, 5'(1) << rr_exp[k]);
      check($sformatf("rr_sel_%0d", k), sel(4), rr_exp[k]);
      check($sformatf("rr_en_%0d", k), port_en_o, 5'b10000);
      credit_inc_i = 5'b10000;
    end
    check("rr_cnt", cnt(4), 3'd3);
    check("rr_err", err_o, 1'b0);

    // ---------------- credit exhaustion on output E ----------------
    reset_dut();
    req_valid_i = 5'b10000;
    set_dest(4, 3'd2);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (port_en_o[2]) n++;
    end
    check("exh_grants", n, 4);
    check("exh_cnt", cnt(2), 3'd0);
    credit_inc_i = 5'b00100;
    step();
    credit_inc_i = 5'b00000;
    check("exh_inc_en", port_en_o[2], 1'b0);
    check("exh_inc_cnt", cnt(2), 3'd1);
    step();
    check("exh_regrant_en", port_en_o, 5'b00100);
    check("exh_regrant_pop", pop_o, 5'b10000);
    check("exh_regrant_sel", sel(2), 3'd4);
    check("exh_regrant_cnt", cnt(2), 3'd0);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (port_en_o[2]) n++;
    end
    check("exh_after_grants", n, 0);
    credit_inc_i = 5'b00100;
    step();
    check("same_pre_cnt", cnt(2), 3'd1);
    step();
    credit_inc_i = 5'b00000;
    check("same_en", port_en_o[2], 1'b1);
    check("same_cnt", cnt(2), 3'd1);
    check("exh_err", err_o, 1'b0);

    // ---------------- error: credit overflow ----------------
    reset_dut();
    credit_inc_i = 5'b00010;
    step();
    credit_inc_i = 5'b00000;
    check("ovf_cnt", cnt(1), 3'd4);
    check("ovf_err", err_o, 1'b1);
    step();
    check("ovf_err_sticky", err_o, 1'b1);

    // ---------------- error: disabled destination ----------------
    check("pe_err_init", pe_err, 1'b0);
    pe_req_valid = 5'b00100;
    pe_req_port  = 15'(0) << 6;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (pe_pop != 5'b0 || pe_port_en != 5'b0) n++;
    end
    check("pe_no_grant", n, 0);
    check("pe_err", pe_err, 1'b1);
    pe_req_valid = 5'b00000;

    // ---------------- error: destination out of range ----------------
    reset_dut();
    step();
    check("bad_dest_err_clr", err_o, 1'b0);
    req_valid_i = 5'b00010;
    set_dest(1, 3'd5);
    step();
    check("bad_dest_err", err_o, 1'b1);
    check("bad_dest_pop", pop_o, 5'b0);

    // ---------------- async reset mid-stream ----------------
    reset_dut();
    req_valid_i = 5'b00011;
    set_dest(0, 3'd3); set_dest(1, 3'd3);
    step();
    check("ar_w0", sel(3), 3'd0);
    step();
    check("ar_w1", sel(3), 3'd1);
    step();
    check("ar_w2", sel(3), 3'd0);
    check("ar_pre_cnt", cnt(3), 3'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_pop", pop_o, 5'b0);
    check("ar_en", port_en_o, 5'b0);
    check("ar_sel", port_sel_o, 15'b0);
    check("ar_cnt", credit_cnt_o, 15'o44444);
    #1;
    rst = 1'b1;
    step();
    check("ar_resume_pop", pop_o, 5'b00001);
    check("ar_resume_en", port_en_o, 5'b01000);
    check("ar_resume_sel", sel(3), 3'd0);
    check("ar_resume_cnt", cnt(3), 3'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
